// File: rtl/data_path_pkg.sv
// rtl/data_path_pkg.sv - shared ALU encodings, register-file sizing and immediate helper
package data_path_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_AW   = $clog2(NUM_REGS);

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  function automatic logic [31:0] sign_ext(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/data_path_alu.sv
// rtl/data_path_alu.sv - combinational ALU with zero flag
// Ports: a, b operands; op selects AND/OR/ADD/SUB/SLT (other codes give 0);
//        result and zero (result == 0).
module data_path_alu
  import data_path_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] result,
  output logic         zero
);

  always_comb begin
    result = '0;
    case (op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/data_path_reg_file.sv
// rtl/data_path_reg_file.sv - 32-entry register file, two combinational reads, one clocked write
// Ports: clk, reset_n (async, active-low); ra1/ra2 read addresses -> rd1/rd2;
//        we/wa/wd write port sampled at posedge clk.
module data_path_reg_file
  import data_path_pkg::*;
#(
  parameter int W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [W-1:0]      wd,
  output logic [W-1:0]      rd1,
  output logic [W-1:0]      rd2
);

  logic [W-1:0] regs [NUM_REGS];

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  // Reads see the pre-edge contents; no write-through bypass.
  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/data_path.sv
// rtl/data_path.sv - single-cycle MIPS datapath: PC, register file, ALU, next-PC select
// Ports: clk, reset_n (async, active-low); instr from instruction memory; read_data from
//        data memory; controls MemtoReg, PCsrc, ALUsrc, RegDst, RegWrite, JMP, ALUcontrol;
//        outputs pc (fetch address), ALUout (data address), write_data (store data), zero.
module data_path
  import data_path_pkg::*;
#(
  parameter int n_bits = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [n_bits-1:0] read_data,
  input  logic [n_bits-1:0] instr,
  input  logic              MemtoReg,
  input  logic              PCsrc,
  input  logic              ALUsrc,
  input  logic              RegDst,
  input  logic              RegWrite,
  input  logic              JMP,
  input  logic [2:0]        ALUcontrol,
  output logic              zero,
  output logic [n_bits-1:0] pc,
  output logic [n_bits-1:0] ALUout,
  output logic [n_bits-1:0] write_data
);

  logic [REG_AW-1:0] rs, rt, rd, write_reg;
  logic [n_bits-1:0] sign_imm, rd1, rd2, alu_b, result;
  logic [n_bits-1:0] pc_plus4, pc_branch, pc_next;
  logic              unused_opcode;

  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign sign_imm = sign_ext(instr[15:0]);

  // Opcode bits are decoded by the external controller, not here.
  assign unused_opcode = ^instr[31:26];

  assign write_reg = RegDst ? rd : rt;
  assign result    = MemtoReg ? read_data : ALUout;

  data_path_reg_file #(.W(n_bits)) u_reg_file (
    .clk     (clk),
    .reset_n (reset_n),
    .ra1     (rs),
    .ra2     (rt),
    .we      (RegWrite),
    .wa      (write_reg),
    .wd      (result),
    .rd1     (rd1),
    .rd2     (rd2)
  );

  assign alu_b = ALUsrc ? sign_imm : rd2;

  data_path_alu #(.W(n_bits)) u_alu (
    .a      (rd1),
    .b      (alu_b),
    .op     (ALUcontrol),
    .result (ALUout),
    .zero   (zero)
  );

  assign write_data = rd2;

  assign pc_plus4  = pc + n_bits'(4);
  assign pc_branch = pc_plus4 + {sign_imm[n_bits-3:0], 2'b00};

  // Jump wins over a taken branch.
  always_comb begin
    pc_next = pc_plus4;
    if (JMP)        pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (PCsrc) pc_next = pc_branch;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc <= '0;
    else          pc <= pc_next;
  end

endmodule

// File: tb/tb_data_path.sv
// tb/tb_data_path.sv - scoreboard bench for data_path against a behavioural MIPS model
module tb_data_path;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] read_data, instr;
  logic        MemtoReg, PCsrc, ALUsrc, RegDst, RegWrite, JMP;
  logic [2:0]  ALUcontrol;
  logic        zero;
  logic [31:0] pc, ALUout, write_data;

  data_path #(.n_bits(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .read_data  (read_data),
    .instr      (instr),
    .MemtoReg   (MemtoReg),
    .PCsrc      (PCsrc),
    .ALUsrc     (ALUsrc),
    .RegDst     (RegDst),
    .RegWrite   (RegWrite),
    .JMP        (JMP),
    .ALUcontrol (ALUcontrol),
    .zero       (zero),
    .pc         (pc),
    .ALUout     (ALUout),
    .write_data (write_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [31:0] alu;
    logic        zero;
    logic [31:0] wd;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          step  = 0;
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s step %0d: got %h expected %h", name, id, act, req);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd6: return a - b;
      3'd7: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Drive one instruction, queue its expected combinational response, then retire it in the model.
  task automatic apply(input logic [31:0] i, input logic [2:0] op, input logic alusrc, input logic regdst,
                       input logic regwrite, input logic memtoreg, input logic pcsrc, input logic jmp,
                       input logic [31:0] rdata);
    logic [31:0] a, b2, simm, res, nxt, p4, wb;
    int          rs, rt, rd, wr;
    exp_t        e;
    instr = i; ALUcontrol = op; ALUsrc = alusrc; RegDst = regdst; RegWrite = regwrite;
    MemtoReg = memtoreg; PCsrc = pcsrc; JMP = jmp; read_data = rdata;
    rs = int'(i[25:21]); rt = int'(i[20:16]); rd = int'(i[15:11]);
    a    = m_regs[rs];
    b2   = m_regs[rt];
    simm = 32'(signed'(i[15:0]));
    res  = alu_ref(op, a, alusrc ? simm : b2);
    step++;
    e.id = step; e.pc = m_pc; e.alu = res; e.zero = (res == 0); e.wd = b2;
    exp_q.push_back(e);
    p4 = m_pc + 32'd4;
    if (jmp)        nxt = {p4[31:28], i[25:0], 2'b00};
    else if (pcsrc) nxt = p4 + simm * 4;
    else            nxt = p4;
    wb = memtoreg ? rdata : res;
    wr = regdst ? rd : rt;
    @(posedge clk); #1;
    if (regwrite && wr != 0) m_regs[wr] = wb;
    m_pc = nxt;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("pc", e.id, pc, e.pc);
      check("ALUout", e.id, ALUout, e.alu);
      check("zero", e.id, {31'd0, zero}, {31'd0, e.zero});
      check("write_data", e.id, write_data, e.wd);
    end
  end

  initial begin
    for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
    m_pc = 32'd0;
    reset_n = 1'b0; instr = 32'h02108020; read_data = 32'd0;
    MemtoReg = 0; PCsrc = 0; ALUsrc = 0; RegDst = 0; RegWrite = 0; JMP = 0; ALUcontrol = 3'b010;
    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", 0, pc, 32'd0);
    check("reset_write_data", 0, write_data, 32'd0);
    reset_n = 1'b1;

    //    instr         op      src rdst rw  m2r pcs jmp rdata
    apply(32'h00008020, 3'b010, 0,  0,   0,  0,  0,  0,  32'd0);   // add, zero=1
    apply(32'h20100007, 3'b010, 1,  0,   1,  0,  0,  0,  32'd0);   // addi $16=7
    apply(32'h10000003, 3'b110, 0,  0,   0,  0,  1,  0,  32'd0);   // branch at pc 8 -> 24
    apply(32'h1000FFFF, 3'b110, 0,  0,   0,  0,  1,  0,  32'd0);   // branch -1 at 24 -> 24
    apply(32'h02108020, 3'b010, 0,  1,   0,  0,  0,  0,  32'd0);   // 7+7=14, wd=7
    apply(32'h8c110000, 3'b010, 1,  0,   1,  1,  0,  0,  32'd30);  // lw $17=30
    apply(32'h00118020, 3'b010, 0,  1,   0,  0,  0,  0,  32'd0);   // read $17 -> wd=30
    apply(32'h20000005, 3'b010, 1,  0,   1,  0,  0,  0,  32'd0);   // write to $0 ignored
    apply(32'h00008020, 3'b001, 0,  1,   0,  0,  0,  0,  32'd0);   // $0 | $0 = 0
    apply(32'h02118020, 3'b110, 0,  1,   0,  0,  0,  0,  32'd0);   // 7-30
    apply(32'h02118020, 3'b111, 0,  1,   0,  0,  0,  0,  32'd0);   // slt 7<30
    apply(32'h02308020, 3'b111, 0,  1,   0,  0,  0,  0,  32'd0);   // slt 30<7
    apply(32'h02118020, 3'b000, 0,  1,   0,  0,  0,  0,  32'd0);   // and = 6
    apply(32'h02118020, 3'b001, 0,  1,   0,  0,  0,  0,  32'd0);   // or = 31
    apply(32'h02108020, 3'b110, 0,  1,   0,  0,  0,  0,  32'd0);   // 7-7, zero=1
    apply(32'h02118020, 3'b011, 0,  1,   0,  0,  0,  0,  32'd0);   // unused codes -> 0
    apply(32'h02118020, 3'b100, 0,  1,   0,  0,  0,  0,  32'd0);
    apply(32'h02118020, 3'b101, 0,  1,   0,  0,  0,  0,  32'd0);
    apply(32'h08000010, 3'b010, 0,  0,   0,  0,  1,  1,  32'd0);   // jump beats branch -> 0x40
    apply(32'h00000000, 3'b010, 0,  0,   0,  0,  0,  0,  32'd0);   // observe pc = 0x40

    for (int n = 0; n < 300; n++) begin
      apply($urandom, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), $urandom);
    end

    // Reset mid-cycle with a write pending: PC and registers clear at once, write lost.
    instr = 32'h20120009; ALUsrc = 1; RegDst = 0; RegWrite = 1; MemtoReg = 0;
    PCsrc = 0; JMP = 0; ALUcontrol = 3'b010;
    #2 reset_n = 1'b0;
    #1;
    check("midreset_pc", step, pc, 32'd0);
    instr = 32'h00128020;
    #1;
    check("midreset_rd_r18", step, write_data, 32'd0);
    instr = 32'h02118020; ALUsrc = 0;
    @(posedge clk); #1;
    check("midreset_hold_pc", step, pc, 32'd0);
    check("midreset_r16_r17", step, ALUout, 32'd0);

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
    if (exp_q.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_path.md
Name: data_path

Overview:
- Datapath of the single-cycle MIPS processor: program counter, 32x32 register file, sign extension, ALU, and next-PC selection (sequential, branch, jump).
- Driven by the external controller through control inputs; talks to external instruction and data memories via `pc`, `instr`, `ALUout`, `write_data`, `read_data`.
- One instruction completes per clock.

Parameters:
- n_bits, 32, data/address width. Only 32 is supported; instruction field positions are fixed MIPS encodings.

Ports:
- clk  in  1  system clock, rising edge active
- reset_n  in  1  asynchronous active-low reset
- read_data  in  n_bits  data-memory read value (load result)
- instr  in  n_bits  current instruction from instruction memory
- MemtoReg  in  1  1: writeback = read_data; 0: writeback = ALUout
- PCsrc  in  1  1: take branch target (controller ANDs branch with zero)
- ALUsrc  in  1  1: ALU B = sign-extended immediate; 0: B = register rt
- RegDst  in  1  1: destination = instr[15:11]; 0: destination = instr[20:16]
- RegWrite  in  1  register-file write enable
- JMP  in  1  1: jump target overrides all other next-PC sources
- ALUcontrol  in  3  ALU operation select
- zero  out  1  high when ALUout == 0
- pc  out  n_bits  current PC (instruction-memory address)
- ALUout  out  n_bits  ALU result (data-memory address)
- write_data  out  n_bits  register rt read value (data-memory store data)

Behaviour:
- Clocking and reset: single clock `clk`; reset `reset_n` is asynchronous and active-low.
- Reset (reset_n=0): PC and all 32 registers clear to 0 immediately. Outputs then follow combinationally: pc=0, and with all registers 0, write_data=0.
- Field decode: rs=instr[25:21], rt=instr[20:16], rd=instr[15:11], imm=instr[15:0].
- SignImm = {16{imm[15]}, imm}.
- Register file:
  - Two combinational read ports, rs→RD1 and rt→RD2.
  - One write port at posedge clk when RegWrite=1, address WriteReg = RegDst ? rd : rt, data Result = MemtoReg ? read_data : ALUout.
  - Register 0 always reads 0; writes to it are ignored.
  - A read in the same cycle as a write to that register returns the old value; the new value is visible after the edge.
- ALU: A=RD1, B = ALUsrc ? SignImm : RD2. ALUcontrol codes:
  - 000 AND
  - 001 OR
  - 010 ADD
  - 110 SUB
  - 111 SLT (signed A<B → 1, else 0)
  - 011, 100, 101 → result 0
  - Add/sub wrap modulo 2^32, with no overflow flag.
- zero = (ALUout == 0). Combinational.
- write_data = RD2.
- Next PC:
  - PCPlus4 = pc+4, wrapping modulo 2^32.
  - PCBranch = PCPlus4 + (SignImm<<2).
  - PCnext = JMP ? {PCPlus4[31:28], instr[25:0], 2'b00} : (PCsrc ? PCBranch : PCPlus4).
  - JMP has priority when JMP and PCsrc are both 1.
- PC loads PCnext every posedge clk while reset_n=1. Latency: the register write and the PC update take effect at the same edge.
- Reset mid-operation clears PC and registers immediately. A write pending in that cycle is lost.

Decomposition:
- Shared package: ALUcontrol encodings (ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_SUB=110, ALU_SLT=111) and the register count of 32.
- Natural sub-modules:
  - reg_file: 2 read ports, 1 write port, async reset.
  - alu: combinational, with zero output.
- PC register, muxes and adders stay in data_path.

Test Plan:
- Reset and sequential fetch: hold reset_n=0 → pc=0. Release with instr=32'h00008020 (add $16,$0,$0), ALUcontrol=010, RegDst=0, RegWrite=0 → ALUout=0, zero=1; pc=4 after the next edge.
- ADDI write: instr=32'h20100007, ALUsrc=1, RegDst=0, RegWrite=1, ALUcontrol=010 → ALUout=7, zero=0; $16=7 after the edge. Next instr=32'h02108020, RegDst=1, ALUsrc=0 → ALUout=14, and write_data=7 during that cycle.
- Load writeback: read_data=30, MemtoReg=1, RegWrite=1, instr=32'h8c110000 → $17=30. Follow with add $0-based read of $17 → RD value 30 observed on write_data (instr with rt=17).
- Register zero: write 5 to $0 via instr=32'h20000005, RegWrite=1 → subsequent reads of $0 return 0.
- Branch and jump:
  - At pc=8, instr imm=16'h0003, PCsrc=1 → pc=24.
  - Branch with negative imm 16'hFFFF at pc=24 → pc=24.
  - instr=32'h08000010, JMP=1 and PCsrc=1 → pc=32'h00000040.
- ALU ops with $16=7, $17=30:
  - SUB 7-30 → 32'hFFFFFFE9, zero=0.
  - SLT(7,30) → 1.
  - SLT(30,7) → 0.
  - AND → 6.
  - OR → 31.
  - SUB 7-7 → zero=1.
